// File: rtl/mole_pkg.sv
// Shared types and short-run constants for the mole round controller.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPAWN  = 2'd1,
        ACTIVE = 2'd2,
        OVER   = 2'd3
    } state_t;

    // Short timings so a whole game fits in a few hundred simulated cycles.
    localparam int SIM_GAME_CYCLES = 200;
    localparam int SIM_WIN_INIT    = 20;
    localparam int SIM_WIN_MIN     = 8;
    localparam int SIM_WIN_DECAY   = 4;
    localparam int SIM_LOCK_CYCLES = 10;

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Button/LFSR inputs and game-state outputs of the mole round controller.
interface mole_round_ctrl_if #(
    parameter int N_MOLES = 8,
    parameter int SCORE_W = 8
);
    localparam int IDX_W = $clog2(N_MOLES);

    logic               start;
    logic [N_MOLES-1:0] hit;
    logic [IDX_W-1:0]   rand_idx;
    logic [IDX_W-1:0]   mole_idx;
    logic               mole_valid;
    logic [N_MOLES-1:0] lockout;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] misses;
    logic               game_end;

    modport master (
        output start, hit, rand_idx,
        input  mole_idx, mole_valid, lockout, score, misses, game_end
    );

    modport slave (
        input  start, hit, rand_idx,
        output mole_idx, mole_valid, lockout, score, misses, game_end
    );

endinterface

// File: rtl/mole_round_ctrl_rise_detect.sv
// Rising-edge detector: registers the previous level, flags 0->1 transitions.
module rise_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);
    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (!rst_n) prev <= '0;
        else        prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round FSM: spawns moles, scores hits, counts misses,
// locks out wrong buttons and ends the game on an internal timer.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int N_MOLES     = 8,
    parameter int SCORE_W     = 8,
    parameter int GAME_CYCLES = 15000000,
    parameter int WIN_INIT    = 2000000,
    parameter int WIN_MIN     = 500000,
    parameter int WIN_DECAY   = 50000,
    parameter int LOCK_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    mole_round_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(N_MOLES);
    localparam int GT_W  = $clog2(GAME_CYCLES + 1);
    localparam int WIN_W = $clog2(WIN_INIT + 1);
    localparam int LK_W  = $clog2(LOCK_CYCLES + 1);

    state_t             state;
    logic [IDX_W-1:0]   mole_idx;
    logic               mole_valid;
    logic [N_MOLES-1:0] lockout;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] misses;
    logic               game_end;
    logic [GT_W-1:0]    game_timer;
    logic [WIN_W-1:0]   mole_timer;
    logic [WIN_W-1:0]   window;
    logic [LK_W-1:0]    lock_timer;

    logic               start_rise;
    logic [N_MOLES-1:0] hit_rise;
    logic [N_MOLES-1:0] hit_r;
    logic [N_MOLES-1:0] mole_oh;
    logic [N_MOLES-1:0] wrong;
    logic               hit_ok;
    logic [IDX_W-1:0]   wrap_idx;
    logic [IDX_W-1:0]   spawn_idx;
    logic [WIN_W-1:0]   win_next;

    rise_detect #(.W(1)) u_start_rise (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.start),
        .rise (start_rise)
    );

    rise_detect #(.W(N_MOLES)) u_hit_rise (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.hit),
        .rise (hit_rise)
    );

    assign hit_r = hit_rise & ~lockout;

    always_comb begin
        mole_oh = '0;
        for (int i = 0; i < N_MOLES; i++) mole_oh[i] = (mole_idx == IDX_W'(i));
    end

    assign hit_ok = |(hit_r & mole_oh);
    assign wrong  = hit_r & ~mole_oh;

    // LFSR range can exceed N_MOLES; fold once, then avoid repeating the last mole.
    always_comb begin
        wrap_idx = (int'(rand_idx_in()) >= N_MOLES) ? IDX_W'(int'(rand_idx_in()) - N_MOLES)
                                                    : rand_idx_in();
        spawn_idx = wrap_idx;
        if (wrap_idx == mole_idx)
            spawn_idx = (int'(wrap_idx) == N_MOLES - 1) ? '0 : wrap_idx + 1'b1;
    end

    function automatic logic [IDX_W-1:0] rand_idx_in();
        return bus.rand_idx;
    endfunction

    always_comb begin
        if (int'(window) >= WIN_MIN + WIN_DECAY) win_next = window - WIN_W'(WIN_DECAY);
        else                                     win_next = WIN_W'(WIN_MIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mole_idx   <= '0;
            mole_valid <= 1'b0;
            lockout    <= '0;
            score      <= '0;
            misses     <= '0;
            game_end   <= 1'b0;
            game_timer <= '0;
            mole_timer <= '0;
            window     <= '0;
            lock_timer <= '0;
        end else begin
            // Lockout runs independently of the FSM; state actions below may override it.
            if (lock_timer != '0) begin
                lock_timer <= lock_timer - 1'b1;
                if (lock_timer == LK_W'(1)) lockout <= '0;
            end

            unique case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        score      <= '0;
                        misses     <= '0;
                        lockout    <= '0;
                        lock_timer <= '0;
                        window     <= WIN_W'(WIN_INIT);
                        game_timer <= GT_W'(GAME_CYCLES);
                        game_end   <= 1'b0;
                        state      <= SPAWN;
                    end
                end

                SPAWN: begin
                    if (game_timer != '0) game_timer <= game_timer - 1'b1;
                    mole_idx   <= spawn_idx;
                    mole_timer <= window;
                    mole_valid <= 1'b1;
                    state      <= ACTIVE;
                end

                ACTIVE: begin
                    if (game_timer == '0) begin
                        // Freeze all buttons; a pending lockout must not release them.
                        game_end   <= 1'b1;
                        mole_valid <= 1'b0;
                        lockout    <= '1;
                        lock_timer <= '0;
                        state      <= OVER;
                    end else begin
                        game_timer <= game_timer - 1'b1;
                        if (hit_ok) begin
                            if (score != '1) score <= score + 1'b1;
                            window     <= win_next;
                            mole_valid <= 1'b0;
                            state      <= SPAWN;
                        end else if (mole_timer == '0) begin
                            if (misses != '1) misses <= misses + 1'b1;
                            mole_valid <= 1'b0;
                            state      <= SPAWN;
                        end else begin
                            mole_timer <= mole_timer - 1'b1;
                            if ((|wrong) && lock_timer == '0) begin
                                lockout    <= wrong;
                                lock_timer <= LK_W'(LOCK_CYCLES);
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mole_idx   = mole_idx;
    assign bus.mole_valid = mole_valid;
    assign bus.lockout    = lockout;
    assign bus.score      = score;
    assign bus.misses     = misses;
    assign bus.game_end   = game_end;

endmodule
